// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types, constants and the parity helper for the bus transfer controller.
package bus_xfer_pkg;

    localparam int BUS_W = 8;

    // Controller sequence: idle, address/data setup, driver enabled, bus release.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } state_t;

    // Round-robin pointer: which requester wins a tie.
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_t;

    // Even parity lane: XOR of all data bits, so data+parity has an even count of ones.
    function automatic logic even_par(input logic [BUS_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Requester/driver-side signal bundle for bus_xfer_ctrl.
// master: the requester side (drives requests and data).
// slave:  the controller (drives grants, completions and driver strobes).
interface bus_xfer_ctrl_if;
    import bus_xfer_pkg::*;

    logic             REQ_A;
    logic [0:BUS_W-1] DIN_A;
    logic             REQ_B;
    logic [0:BUS_W-1] DIN_B;
    logic             GNT_A;
    logic             GNT_B;
    logic             DONE_A;
    logic             DONE_B;
    logic             READ;
    logic             WRITE;
    logic [0:BUS_W-1] DIN;
    logic             PIN;
    logic             BUSY;

    modport master (
        output REQ_A, DIN_A, REQ_B, DIN_B,
        input  GNT_A, GNT_B, DONE_A, DONE_B, READ, WRITE, DIN, PIN, BUSY
    );

    modport slave (
        input  REQ_A, DIN_A, REQ_B, DIN_B,
        output GNT_A, GNT_B, DONE_A, DONE_B, READ, WRITE, DIN, PIN, BUSY
    );

endinterface

// File: rtl/bus_xfer_ctrl_arb.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the pointer; the pointer moves to the loser only when the
// controller accepts the grant (advance_i), so a lone requester always wins
// and two persistent requesters alternate.
module rr_arb2
    import bus_xfer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic advance_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    rr_ptr_t ptr_q;
    rr_ptr_t ptr_d;
    logic    gnt_a_s;
    logic    gnt_b_s;

    // Grant selection: tie broken by the pointer, otherwise the lone requester.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (req_a_i && req_b_i) begin
            if (ptr_q == PTR_A) begin
                gnt_a_s = 1'b1;
            end else begin
                gnt_b_s = 1'b1;
            end
        end else if (req_a_i) begin
            gnt_a_s = 1'b1;
        end else if (req_b_i) begin
            gnt_b_s = 1'b1;
        end else begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end
    end

    // Pointer next state: after an accepted grant, favour the other requester.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && gnt_a_s) begin
            ptr_d = PTR_B;
        end else if (advance_i && gnt_b_s) begin
            ptr_d = PTR_A;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register, favouring A out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_a_o = gnt_a_s;
    assign gnt_b_o = gnt_b_s;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Strobe sequencer for the shared 8-bit tristate driver. Arbitrates two
// requesters, latches the winner's byte with its even parity, and walks
// SETUP -> DRIVE -> TURN so the driver (READ=0, WRITE=1) is only enabled on
// stable data and is followed by a bus-release gap. All outputs are registered.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int DRIVE_CYC = 2,
    parameter int TURN_CYC  = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    bus_xfer_ctrl_if.slave  bus
);

    localparam int MAX_CYC = (DRIVE_CYC > TURN_CYC) ? DRIVE_CYC : TURN_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    if ((DRIVE_CYC < 1) || (TURN_CYC < 1)) begin : g_param_check
        $error("bus_xfer_ctrl: DRIVE_CYC and TURN_CYC must both be >= 1");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [0:BUS_W-1] din_q;
    logic             pin_q;
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic             done_a_q;
    logic             done_b_q;
    logic             read_q;
    logic             write_q;
    logic             busy_q;

    logic             arb_gnt_a_s;
    logic             arb_gnt_b_s;
    logic             advance_s;

    // A grant is taken only from IDLE; requests seen mid-transfer wait.
    assign advance_s = (state_q == IDLE) && (bus.REQ_A || bus.REQ_B);

    rr_arb2 u_arb (
        .clk       (CLK),
        .rst_n     (RST_N),
        .req_a_i   (bus.REQ_A),
        .req_b_i   (bus.REQ_B),
        .advance_i (advance_s),
        .gnt_a_o   (arb_gnt_a_s),
        .gnt_b_o   (arb_gnt_b_s)
    );

    // Transfer FSM: state, shared down-counter, data/parity latch and registered strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            din_q    <= '0;
            pin_q    <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            read_q   <= 1'b1;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    if (advance_s) begin
                        state_q <= SETUP;
                        gnt_a_q <= arb_gnt_a_s;
                        gnt_b_q <= arb_gnt_b_s;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (arb_gnt_a_s) begin
                            din_q <= bus.DIN_A;
                            pin_q <= even_par(bus.DIN_A);
                        end else begin
                            din_q <= bus.DIN_B;
                            pin_q <= even_par(bus.DIN_B);
                        end
                    end else begin
                        read_q  <= 1'b1;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q <= DRIVE;
                    write_q <= 1'b1;
                    cnt_q   <= DRIVE_LOAD;
                end
                DRIVE: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= TURN;
                        write_q <= 1'b0;
                        read_q  <= 1'b1;
                        cnt_q   <= TURN_LOAD;
                        // With a single TURN cycle it is also the last one.
                        if (TURN_LOAD == CNT_ZERO) begin
                            done_a_q <= gnt_a_q;
                            done_b_q <= gnt_b_q;
                        end else begin
                            done_a_q <= 1'b0;
                            done_b_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                TURN: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_q  <= IDLE;
                        gnt_a_q  <= 1'b0;
                        gnt_b_q  <= 1'b0;
                        done_a_q <= 1'b0;
                        done_b_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            done_a_q <= gnt_a_q;
                            done_b_q <= gnt_b_q;
                        end else begin
                            done_a_q <= 1'b0;
                            done_b_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= CNT_ZERO;
                    gnt_a_q  <= 1'b0;
                    gnt_b_q  <= 1'b0;
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    read_q   <= 1'b1;
                    write_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.GNT_A  = gnt_a_q;
    assign bus.GNT_B  = gnt_b_q;
    assign bus.DONE_A = done_a_q;
    assign bus.DONE_B = done_b_q;
    assign bus.READ   = read_q;
    assign bus.WRITE  = write_q;
    assign bus.DIN    = din_q;
    assign bus.PIN    = pin_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: default-parameter instance plus a
// DRIVE_CYC=4 / TURN_CYC=3 instance. Each output cycle is packed into a
// 16-bit word {GNT_A,GNT_B,DONE_A,DONE_B,READ,WRITE,BUSY,PIN,DIN[0:7]}.
module tb_bus_xfer_ctrl;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    bus_xfer_ctrl_if bus1 ();
    bus_xfer_ctrl_if bus2 ();

    bus_xfer_ctrl #(.DRIVE_CYC(2), .TURN_CYC(1)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1)
    );

    bus_xfer_ctrl #(.DRIVE_CYC(4), .TURN_CYC(3)) u_dut_long (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    localparam logic [15:0] RST_VEC = 16'h0800;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sample(input bit sel);
        if (sel) begin
            return {bus2.GNT_A, bus2.GNT_B, bus2.DONE_A, bus2.DONE_B,
                    bus2.READ, bus2.WRITE, bus2.BUSY, bus2.PIN, bus2.DIN};
        end else begin
            return {bus1.GNT_A, bus1.GNT_B, bus1.DONE_A, bus1.DONE_B,
                    bus1.READ, bus1.WRITE, bus1.BUSY, bus1.PIN, bus1.DIN};
        end
    endfunction

    task automatic set_req(input bit sel, input bit b, input logic v);
        if (sel) begin
            if (b) bus2.REQ_B = v; else bus2.REQ_A = v;
        end else begin
            if (b) bus1.REQ_B = v; else bus1.REQ_A = v;
        end
    endtask

    task automatic set_din(input bit sel, input bit b, input logic [7:0] d);
        if (sel) begin
            if (b) bus2.DIN_B = d; else bus2.DIN_A = d;
        end else begin
            if (b) bus1.DIN_B = d; else bus1.DIN_A = d;
        end
    endtask

    // One full transfer from the cycle after the granting edge through the
    // following IDLE cycle. Expected: SETUP (c=1), DRIVE (2..1+dc),
    // TURN (2+dc..1+dc+tc) with DONE in the last, IDLE (2+dc+tc).
    task automatic xfer(input bit sel, input bit who_b, input logic [7:0] d, input logic p,
                        input logic [7:0] late_d, input bit drop, input int dc, input int tc,
                        input string tag);
        logic [15:0] exp;
        bit drv, trn, idl, dn, g;
        for (int c = 1; c <= 2 + dc + tc; c++) begin
            @(negedge CLK);
            drv = (c >= 2) && (c <= 1 + dc);
            trn = (c >= 2 + dc) && (c <= 1 + dc + tc);
            idl = (c == 2 + dc + tc);
            dn  = (c == 1 + dc + tc);
            g   = !idl;
            exp = {g && !who_b, g && who_b, dn && !who_b, dn && who_b,
                   trn || idl, drv, !idl, p, d};
            check_val($sformatf("%s_c%0d", tag, c), sample(sel), exp);
            if (c == 2) set_din(sel, who_b, late_d);
            if (drop && dn) set_req(sel, who_b, 1'b0);
        end
    endtask

    initial begin
        bus1.REQ_A = 1'b0; bus1.REQ_B = 1'b0; bus1.DIN_A = 8'h00; bus1.DIN_B = 8'h00;
        bus2.REQ_A = 1'b0; bus2.REQ_B = 1'b0; bus2.DIN_A = 8'h00; bus2.DIN_B = 8'h00;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check_val("rst_dut", sample(1'b0), RST_VEC);
        check_val("rst_dut_long", sample(1'b1), RST_VEC);
        RST_N = 1'b1;
        @(negedge CLK);
        check_val("idle_after_rst", sample(1'b0), RST_VEC);

        // Lone A, A5 has four ones -> PIN=0.
        set_din(1'b0, 1'b0, 8'hA5);
        set_req(1'b0, 1'b0, 1'b1);
        xfer(1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1, 2, 1, "a5");

        // Lone B (pointer now favours B anyway), 07 has three ones -> PIN=1.
        set_din(1'b0, 1'b1, 8'h07);
        set_req(1'b0, 1'b1, 1'b1);
        xfer(1'b0, 1'b1, 8'h07, 1'b1, 8'h07, 1'b1, 2, 1, "b07");

        // DIN_A moves to FF during DRIVE; latched 3C must hold.
        set_din(1'b0, 1'b0, 8'h3C);
        set_req(1'b0, 1'b0, 1'b1);
        xfer(1'b0, 1'b0, 8'h3C, 1'b0, 8'hFF, 1'b1, 2, 1, "hold3c");

        // Reset pulsed in the first DRIVE cycle.
        set_din(1'b0, 1'b0, 8'h5A);
        set_req(1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        check_val("mid_setup", sample(1'b0), 16'h825A);
        @(negedge CLK);
        check_val("mid_drive", sample(1'b0), 16'h865A);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("rst_async", sample(1'b0), RST_VEC);
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check_val($sformatf("no_done_%0d", i), sample(1'b0), RST_VEC);
        end

        // Both requesting from reset: A,B,A,B. 13 -> PIN=1, 22 -> PIN=0.
        set_din(1'b0, 1'b0, 8'h13);
        set_din(1'b0, 1'b1, 8'h22);
        set_req(1'b0, 1'b0, 1'b1);
        set_req(1'b0, 1'b1, 1'b1);
        xfer(1'b0, 1'b0, 8'h13, 1'b1, 8'h13, 1'b0, 2, 1, "rr1a");
        xfer(1'b0, 1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 2, 1, "rr2b");
        xfer(1'b0, 1'b0, 8'h13, 1'b1, 8'h13, 1'b0, 2, 1, "rr3a");
        xfer(1'b0, 1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 2, 1, "rr4b");
        set_req(1'b0, 1'b0, 1'b0);
        set_req(1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        check_val("rr_quiet", sample(1'b0), 16'h0822);

        // Long instance: WRITE 4 cycles, DONE 3 cycles after, period 9.
        set_din(1'b1, 1'b0, 8'hC3);
        set_req(1'b1, 1'b0, 1'b1);
        xfer(1'b1, 1'b0, 8'hC3, 1'b0, 8'hC3, 1'b1, 4, 3, "long1");
        set_din(1'b1, 1'b0, 8'h81);
        set_req(1'b1, 1'b0, 1'b1);
        xfer(1'b1, 1'b0, 8'h81, 1'b0, 8'h81, 1'b1, 4, 3, "long2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
